// File: rtl/gem_cluster_size_sched_pkg.sv
// Shared GEM cluster constants, field positions and scheduler state encoding.
// Imported by the cluster-size scheduler and its tag pipeline.
package gem_cluster_size_sched_pkg;

  localparam int GEM_CLUSTER_BITS = 14;
  localparam int GEM_SIZE_BITS    = 3;
  localparam int GEM_NVFATS       = 24;
  localparam int GEM_VFAT_BITS    = 5;

  localparam int GEM_SIZE_MSB  = 13;
  localparam int GEM_SIZE_LSB  = 11;
  localparam int GEM_VFAT_MSB  = 10;
  localparam int GEM_VFAT_LSB  = 6;
  localparam int GEM_STRIP_MSB = 5;
  localparam int GEM_STRIP_LSB = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef logic [GEM_CLUSTER_BITS-1:0] gem_cluster_t;
  typedef logic [GEM_SIZE_BITS-1:0]    gem_size_t;

  function automatic logic vfat_ok(input gem_cluster_t c);
    return c[GEM_VFAT_MSB:GEM_VFAT_LSB] < GEM_VFAT_BITS'(GEM_NVFATS);
  endfunction

endpackage

// File: rtl/gem_size_tag_pipe.sv
// Delay line carrying {valid, pair index} alongside in-flight ROM lookups,
// so each returned size pair is written to the slots it was issued for.
module gem_size_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int KW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_vld,
  input  logic [KW-1:0] in_k,
  output logic          out_vld,
  output logic [KW-1:0] out_k,
  output logic          busy
);

  logic [DEPTH-1:0] vq;
  logic [KW-1:0]    kq [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      vq <= '0;
      for (int i = 0; i < DEPTH; i++) kq[i] <= '0;
    end else begin
      vq[0] <= in_vld;
      kq[0] <= in_k;
      for (int i = 1; i < DEPTH; i++) begin
        vq[i] <= vq[i-1];
        kq[i] <= kq[i-1];
      end
    end
  end

  assign out_vld = vq[DEPTH-1];
  assign out_k   = kq[DEPTH-1];
  assign busy    = |vq;

endmodule

// File: rtl/gem_cluster_size_sched.sv
// Schedules a GEM cluster burst through the two-port size ROM, one pair per
// clock, and gathers the returned sizes into a per-burst result vector.
module gem_cluster_size_sched
  import gem_cluster_size_sched_pkg::*;
#(
  parameter int NCLUSTERS   = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [GEM_CLUSTER_BITS*NCLUSTERS-1:0] clusters_in,
  input  logic                                 clusters_vld,
  output logic                                 ready,
  output logic [GEM_CLUSTER_BITS-1:0]          lookup_cluster0,
  output logic [GEM_CLUSTER_BITS-1:0]          lookup_cluster1,
  input  logic [GEM_SIZE_BITS-1:0]             lookup_size0,
  input  logic [GEM_SIZE_BITS-1:0]             lookup_size1,
  output logic [GEM_SIZE_BITS*NCLUSTERS-1:0]   sizes_out,
  output logic [NCLUSTERS-1:0]                 sizes_mask,
  output logic                                 sizes_vld,
  output logic [7:0]                           drop_cnt
);

  localparam int NPAIRS = NCLUSTERS / 2;
  localparam int KW     = $clog2(NPAIRS + 1);
  localparam int CB     = GEM_CLUSTER_BITS;
  localparam int SB     = GEM_SIZE_BITS;

  logic [1:0]               state;
  logic [KW-1:0]            k;
  logic [CB*NCLUSTERS-1:0]  burst;
  logic                     last;
  logic                     accept;
  gem_cluster_t             nxt0;
  gem_cluster_t             nxt1;
  logic                     tag_vld;
  logic [KW-1:0]            tag_k;
  logic                     tag_busy;

  assign ready     = (state == ST_IDLE);
  assign sizes_vld = (state == ST_DONE);
  assign accept    = ready && clusters_vld;
  assign last      = (k == KW'(NPAIRS - 1));

  // Next pair is pre-registered so the lookup ports stay registered outputs.
  always_comb begin
    nxt0 = '0;
    nxt1 = '0;
    for (int p = 0; p < NPAIRS; p++) begin
      if (KW'(p) == k + KW'(1)) begin
        nxt0 = burst[CB*(2*p)   +: CB];
        nxt1 = burst[CB*(2*p+1) +: CB];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      k               <= '0;
      burst           <= '0;
      lookup_cluster0 <= '0;
      lookup_cluster1 <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (clusters_vld) begin
            burst           <= clusters_in;
            k               <= '0;
            lookup_cluster0 <= clusters_in[0  +: CB];
            lookup_cluster1 <= clusters_in[CB +: CB];
            state           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          k <= k + KW'(1);
          if (last) begin
            lookup_cluster0 <= '0;
            lookup_cluster1 <= '0;
            state           <= ST_DRAIN;
          end else begin
            lookup_cluster0 <= nxt0;
            lookup_cluster1 <= nxt1;
          end
        end
        ST_DRAIN: if (!tag_busy) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  gem_size_tag_pipe #(
    .DEPTH (ROM_LATENCY),
    .KW    (KW)
  ) u_tag (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (state == ST_ISSUE),
    .in_k    (k),
    .out_vld (tag_vld),
    .out_k   (tag_k),
    .busy    (tag_busy)
  );

  // Writeback follows the tag pipe only; invalid VFATs land as zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      sizes_out  <= '0;
      sizes_mask <= '0;
    end else if (accept) begin
      sizes_out  <= '0;
      sizes_mask <= '0;
    end else if (tag_vld) begin
      for (int i = 0; i < NCLUSTERS; i++) begin
        if (tag_k == KW'(i / 2)) begin
          if (vfat_ok(burst[CB*i +: CB])) begin
            sizes_out[SB*i +: SB] <= (i % 2 == 0) ? lookup_size0 : lookup_size1;
            sizes_mask[i]         <= 1'b1;
          end else begin
            sizes_out[SB*i +: SB] <= '0;
            sizes_mask[i]         <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (clusters_vld && !ready && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_gem_cluster_size_sched.sv
// Bench for gem_cluster_size_sched: directed and random bursts against a
// slot-level reference model, at two parameter sets.
module tb_gem_cluster_size_sched;

  localparam int N  = 8;
  localparam int L  = 1;
  localparam int N2 = 4;
  localparam int L2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [14*N-1:0] cin;
  logic          cvld;
  logic          ready;
  logic [13:0]   lc0, lc1;
  logic [2:0]    ls0, ls1;
  logic [3*N-1:0] sz;
  logic [N-1:0]  msk;
  logic          svld;
  logic [7:0]    drop;

  logic [14*N2-1:0] cin2;
  logic          cvld2;
  logic          ready2;
  logic [13:0]   lc0_2, lc1_2;
  logic [2:0]    ls0_2, ls1_2;
  logic [3*N2-1:0] sz2;
  logic [N2-1:0] msk2;
  logic          svld2;
  logic [7:0]    drop2;

  gem_cluster_size_sched #(.NCLUSTERS(N), .ROM_LATENCY(L)) dut (
    .clock(clk), .reset(reset), .clusters_in(cin), .clusters_vld(cvld),
    .ready(ready), .lookup_cluster0(lc0), .lookup_cluster1(lc1),
    .lookup_size0(ls0), .lookup_size1(ls1), .sizes_out(sz),
    .sizes_mask(msk), .sizes_vld(svld), .drop_cnt(drop)
  );

  gem_cluster_size_sched #(.NCLUSTERS(N2), .ROM_LATENCY(L2)) dut2 (
    .clock(clk), .reset(reset), .clusters_in(cin2), .clusters_vld(cvld2),
    .ready(ready2), .lookup_cluster0(lc0_2), .lookup_cluster1(lc1_2),
    .lookup_size0(ls0_2), .lookup_size1(ls1_2), .sizes_out(sz2),
    .sizes_mask(msk2), .sizes_vld(svld2), .drop_cnt(drop2)
  );

  // Behavioural size ROM: address in cycle c, data visible from c+latency.
  logic [2:0] romtab [8] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4};
  logic [13:0] q0 [4], q1 [4], r0 [4], r1 [4];

  always @(posedge clk) begin
    q0[0] <= lc0;
    q1[0] <= lc1;
    r0[0] <= lc0_2;
    r1[0] <= lc1_2;
    for (int i = 1; i < 4; i++) begin
      q0[i] <= q0[i-1];
      q1[i] <= q1[i-1];
      r0[i] <= r0[i-1];
      r1[i] <= r1[i-1];
    end
  end

  assign ls0   = romtab[q0[L-1][13:11]];
  assign ls1   = romtab[q1[L-1][13:11]];
  assign ls0_2 = romtab[r0[L2-1][13:11]];
  assign ls1_2 = romtab[r1[L2-1][13:11]];

  int vectors = 0;
  int miscompares = 0;
  int dropm = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [223:0] b, input int n,
                                output logic [47:0] es, output logic [15:0] em);
    logic [13:0] c;
    es = '0;
    em = '0;
    for (int i = 0; i < n; i++) begin
      c = b[14*i +: 14];
      if (c[10:6] < 5'd24) begin
        es[3*i +: 3] = romtab[c[13:11]];
        em[i] = 1'b1;
      end
    end
  endfunction

  function automatic logic [14*N-1:0] rand_burst();
    logic [14*N-1:0] b;
    for (int i = 0; i < N; i++) b[14*i +: 14] = 14'($urandom);
    return b;
  endfunction

  // Strobe at n=0; drops[n] re-strobes while busy in cycle T+n.
  task automatic burst(input logic [14*N-1:0] b, input logic [15:0] drops);
    logic [47:0] es;
    logic [15:0] em;
    int n;
    bit got;
    model({{(224-14*N){1'b0}}, b}, N, es, em);
    chk("ready_before", ready, 1);
    cin = b;
    cvld = 1'b1;
    @(negedge clk);
    n = 1;
    got = 0;
    while (!got && n < 40) begin
      if (n <= N / 2) begin
        chk("lookup0", lc0, b[28*(n-1) +: 14]);
        chk("lookup1", lc1, b[28*(n-1)+14 +: 14]);
      end
      if (n == N / 2 + 1) chk("lookup_idle", {lc1, lc0}, 0);
      if (svld) begin
        got = 1;
        chk("latency", n, 2 + N / 2 + L);
        chk("sizes", sz, es[3*N-1:0]);
        chk("mask", msk, em[N-1:0]);
        chk("ready_done", ready, 0);
      end
      if (n < 16 && drops[n]) begin
        cvld = 1'b1;
        cin = rand_burst();
        if (dropm < 255) dropm++;
      end else begin
        cvld = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    cvld = 1'b0;
    if (!got) chk("sizes_vld_timeout", 0, 1);
    chk("ready_after", ready, 1);
    chk("svld_after", svld, 0);
    chk("sizes_hold", sz, es[3*N-1:0]);
    chk("drop_cnt", drop, dropm);
  endtask

  task automatic burst2(input logic [14*N2-1:0] b);
    logic [47:0] es;
    logic [15:0] em;
    int n;
    bit got;
    model({{(224-14*N2){1'b0}}, b}, N2, es, em);
    chk("ready2_before", ready2, 1);
    cin2 = b;
    cvld2 = 1'b1;
    @(negedge clk);
    cvld2 = 1'b0;
    n = 1;
    got = 0;
    while (!got && n < 40) begin
      if (svld2) begin
        got = 1;
        chk("latency2", n, 2 + N2 / 2 + L2);
        chk("sizes2", sz2, es[3*N2-1:0]);
        chk("mask2", msk2, em[N2-1:0]);
      end
      @(negedge clk);
      n++;
    end
    if (!got) chk("sizes_vld2_timeout", 0, 1);
    chk("ready2_after", ready2, 1);
  endtask

  initial begin
    logic [14*N-1:0] b;
    logic [14*N2-1:0] b2;

    reset = 1'b1;
    cvld = 1'b0;
    cin = '0;
    cvld2 = 1'b0;
    cin2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_svld", svld, 0);
    chk("rst_sizes", sz, 0);
    chk("rst_mask", msk, 0);
    chk("rst_lookup", {lc1, lc0}, 0);
    chk("rst_drop", drop, 0);

    for (int i = 0; i < N; i++) b[14*i +: 14] = {3'(i), 5'd3, 6'(i)};
    burst(b, 16'h0000);
    chk("single_sizes", sz, 24'b100_100_011_010_010_001_000_000);
    chk("single_mask", msk, 8'hFF);

    b[14*2 +: 14] = {3'd2, 5'd24, 6'd9};
    b[14*7 +: 14] = {3'd7, 5'd31, 6'd1};
    burst(b, 16'h0000);
    chk("invalid_mask", msk, 8'h7B);

    burst(rand_burst(), 16'h0088);
    chk("drop_two", drop, 2);
    burst(rand_burst(), 16'h0000);

    // Reset three cycles into a burst, after one dropped strobe.
    cin = rand_burst();
    cvld = 1'b1;
    @(negedge clk);
    cin = rand_burst();
    @(negedge clk);
    cvld = 1'b0;
    if (dropm < 255) dropm++;
    chk("pre_rst_drop", drop, dropm);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dropm = 0;
    chk("midrst_ready", ready, 1);
    chk("midrst_svld", svld, 0);
    chk("midrst_sizes", sz, 0);
    chk("midrst_mask", msk, 0);
    chk("midrst_drop", drop, 0);
    burst(rand_burst(), 16'h0000);

    for (int r = 0; r < 20; r++) burst(rand_burst(), 16'($urandom) & 16'h00FE);
    for (int r = 0; r < 44; r++) burst(rand_burst(), 16'h00FE);
    chk("drop_saturated", drop, 255);

    for (int i = 0; i < N2; i++) b2[14*i +: 14] = {3'(i + 4), 5'd5, 6'(i)};
    burst2(b2);
    chk("p2_sizes", sz2, 12'b100_100_011_010);
    chk("p2_mask", msk2, 4'hF);
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N2; i++) b2[14*i +: 14] = 14'($urandom);
      burst2(b2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gem_cluster_size_sched.md
# gem_cluster_size_sched

Time-multiplexes a burst of GEM clusters through the two-port cluster-size lookup ROM (two lookups per clock) and gathers the returned sizes into one per-burst result vector. Sits between the GEM cluster receiver, which delivers one burst of NCLUSTERS clusters per strobe, and the GEM–CSC matching logic. It owns both ROM address ports and tracks in-flight lookups so each returned size lands in the correct slot.

## Interface
- NCLUSTERS, 8, clusters per burst; even, 2..16
- ROM_LATENCY, 1, cycles from address presented on the lookup ports to size visible on the return ports; 1..4
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- clusters_in  in  14*NCLUSTERS  packed burst; slot i at [14*i+13:14*i]; per cluster, [13:11] size, [10:6] VFAT id, [5:0] strip
- clusters_vld  in  1  one-cycle strobe qualifying clusters_in
- ready  out  1  high when a strobe will be accepted
- lookup_cluster0  out  14  ROM port-0 address cluster (even slot)
- lookup_cluster1  out  14  ROM port-1 address cluster (odd slot)
- lookup_size0  in  3  ROM port-0 result
- lookup_size1  in  3  ROM port-1 result
- sizes_out  out  3*NCLUSTERS  translated sizes; slot i at [3*i+2:3*i]
- sizes_mask  out  NCLUSTERS  bit i set = slot i valid cluster
- sizes_vld  out  1  one-cycle pulse, sizes_out/sizes_mask complete
- drop_cnt  out  8  saturating count of strobes dropped while not ready

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE. Reset → IDLE.
- IDLE: ready=1. When clusters_vld is high, register clusters_in, clear pair index k, and go to ISSUE.
- ISSUE: drive pair k, with lookup_cluster0 = slot 2k and lookup_cluster1 = slot 2k+1. k increments once per cycle. After pair NCLUSTERS/2−1, go to DRAIN.
- DRAIN: wait until the tag pipeline holds no valid entries, then go to DONE.
- DONE: pulse sizes_vld for one cycle, then go to IDLE.
- Tag pipeline:
  - Depth ROM_LATENCY, carrying {valid, k}, loaded each ISSUE cycle.
  - When an entry exits, write lookup_size0 to slot 2k and lookup_size1 to slot 2k+1.
  - Writeback runs independently of FSM state.
- Cluster validity: slot is valid iff VFAT id < 24.
  - Invalid slot: sizes_out slot forced to 0 and its sizes_mask bit cleared.
  - The address is still issued, so the schedule stays fixed.
- sizes_out and sizes_mask are cleared on acceptance of a new burst. They hold from the DONE cycle until the next acceptance.
- Lookup ports outside ISSUE: drive 14'h0.
- Dropped strobe: any clusters_vld while ready=0.
  - drop_cnt increments and saturates at 255.
  - No other effect; the in-progress burst is undisturbed.
- Reset mid-burst:
  - FSM goes to IDLE; tag pipeline, sizes_out, sizes_mask, drop_cnt and sizes_vld are cleared.
  - In-flight ROM results are discarded.

## Timing
- Reset values: ready=1; sizes_vld=0; sizes_out=0; sizes_mask=0; lookup_cluster0/1=0; drop_cnt=0.
- Strobe accepted in cycle T: pair k presented on the lookup ports during cycle T+1+k.
- Results for pair k are sampled at the end of cycle T+1+k+ROM_LATENCY.
- sizes_vld is high in cycle T+2+NCLUSTERS/2+ROM_LATENCY. Defaults: T+7.
- ready is low from T+1 through the DONE cycle inclusive. The earliest next acceptance is the cycle after DONE.
  - Default throughput: one burst per 8 cycles.
- A strobe in the DONE cycle counts as dropped.
- Lookup outputs are registered; there is no combinational path from clusters_in to the lookup ports.

## Structure
- Shared GEM package constants:
  - GEM_CLUSTER_BITS=14, GEM_SIZE_BITS=3, GEM_NVFATS=24
  - bit-field positions for size [13:11], VFAT id [10:6], strip [5:0]
  - FSM state encoding
- Sub-module gem_size_tag_pipe: the ROM_LATENCY-deep {valid, k} delay line. It has a synchronous clear on reset.
- The ROM is not instantiated here. The parent wires the lookup ports to it.

## Test plan
- Single burst: all 8 slots with VFAT 3, sizes 0..7, and a behavioural ROM model (0,0,1,2,2,3,4,4) at ROM_LATENCY=1.
  - Required response: sizes_vld at T+7, sizes_out slots = 0,0,1,2,2,3,4,4, sizes_mask=8'hFF.
- Invalid slots: VFAT 24 in slot 2 and VFAT 31 in slot 7, other slots valid.
  - Required response: those two slots read 0, sizes_mask=8'h7B.
- Strobes at T, T+3 and T+7.
  - Required response: T+3 dropped (drop_cnt=1); T+7 dropped because it falls in DONE (drop_cnt=2); a strobe at T+8 is accepted.
- Assert reset at T+3 of a burst.
  - Required response: next cycle state is IDLE, ready=1, sizes_out=0, and no sizes_vld pulse.
  - A new burst at T+5 completes normally.
- ROM_LATENCY=3, NCLUSTERS=4.
  - Required response: sizes_vld at T+7, slot alignment correct.
- 300 strobes while busy.
  - Required response: drop_cnt saturates at 255.
